// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over open-drain PS/2 clock/data enables.
// Define PS2_TX_TIMEOUT_EN to abort a frame that is not finished TIMEOUT_CYCLES after clock release.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       send,
    input  logic [7:0] send_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    if (INHIBIT_CYCLES < 1) begin : g_bad_inhibit
        $error("INHIBIT_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 20-bit timeout counter");
    end

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, DONE, FAIL
    } state_t;

    state_t state, state_next;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic clk_fall;
    logic [INH_W-1:0] inh_cnt;
    logic [9:0] shift_reg;
    logic tx_low;
    logic [3:0] bit_cnt;

    assign clk_fall = clk_prev & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] to_cnt;
    logic timeout;

    assign timeout = (to_cnt == TO_LAST);

    // Counts cycles since clock release; REQ is cycle 0 so FAIL lands exactly TIMEOUT_CYCLES later.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= 20'd1;
        end else if (state == XFER || state == ACK || state == WAIT_IDLE) begin
            to_cnt <= to_cnt + 20'd1;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register holds data, parity and stop; each falling edge puts the next bit on the line.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            dat_meta  <= 1'b1;
            dat_sync  <= 1'b1;
            inh_cnt   <= '0;
            shift_reg <= '0;
            tx_low    <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            case (state)
                IDLE: begin
                    inh_cnt <= '0;
                    if (send) begin
                        shift_reg <= {1'b1, ~^send_data, send_data};
                    end
                end
                INHIBIT: inh_cnt <= inh_cnt + 1'b1;
                REQ: begin
                    bit_cnt <= '0;
                    tx_low  <= 1'b1;
                end
                XFER: begin
                    if (clk_fall) begin
                        tx_low    <= ~shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[9:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (send) state_next = INHIBIT;
            INHIBIT:   if (inh_cnt == INH_LAST) state_next = REQ;
            REQ:       state_next = XFER;
            XFER:      if (clk_fall && bit_cnt == 4'd9) state_next = ACK;
            ACK:       if (clk_fall) state_next = dat_sync ? FAIL : WAIT_IDLE;
            WAIT_IDLE: if (clk_sync && dat_sync) state_next = DONE;
            DONE:      state_next = IDLE;
            FAIL:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if ((state == XFER || state == ACK || state == WAIT_IDLE) && timeout) begin
            state_next = FAIL;
        end
`endif
    end

    always_comb begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = (inh_cnt == INH_LAST);
                busy       = 1'b1;
            end
            REQ: begin
                ps2_dat_oe = 1'b1;
                busy       = 1'b1;
            end
            XFER: begin
                ps2_dat_oe = tx_low;
                busy       = 1'b1;
            end
            ACK:       busy  = 1'b1;
            WAIT_IDLE: busy  = 1'b1;
            DONE:      done  = 1'b1;
            FAIL:      error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device on open-drain lines.
// Expected bytes, parity and pulse counts come from the bench's own frame model.
module tb_ps2_host_tx;
    localparam int INHIBIT = 40;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 20;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       send = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       pin_clk, pin_dat;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int error_cnt = 0;
    int both_cnt = 0;
    int busy_at_done = 0;

    logic [7:0] dev_rx;
    logic       dev_par, dev_stop, dev_start;
    int         dev_inh;
    logic       dev_ok;

    assign pin_clk = ~(ps2_clk_oe | dev_clk_low);
    assign pin_dat = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .send       (send),
        .send_data  (send_data),
        .ps2_clk_in (pin_clk),
        .ps2_dat_in (pin_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) busy_at_done++;
            end
            if (error === 1'b1) error_cnt++;
            if (done === 1'b1 && error === 1'b1) both_cnt++;
        end
    end

    initial begin
        repeat (90000) @(posedge CLOCK_50);
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelParity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) ones++;
        end
        return (ones % 2 == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge CLOCK_50);
        send      = 1'b1;
        send_data = b;
        @(negedge CLOCK_50);
        send      = 1'b0;
        send_data = 8'($urandom);
    endtask

    // Device: waits for the host request, clocks 10 bits sampling on rising edges, then ACKs or NACKs.
    task automatic deviceFrame(input bit do_ack, input int stop_at);
        logic [9:0] bits;
        int w;
        bits = '0;
        w = 0;
        dev_ok = 1'b1;
        dev_inh = 0;
        dev_start = 1'b1;
        while (ps2_clk_oe !== 1'b1 && w < 3000) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (w >= 3000) begin
            dev_ok = 1'b0;
            return;
        end
        while (ps2_clk_oe === 1'b1 && dev_inh < 3000) begin
            dev_inh++;
            @(negedge CLOCK_50);
        end
        repeat (5) @(negedge CLOCK_50);
        dev_start = pin_dat;
        for (int n = 1; n <= 10; n++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLOCK_50);
            if (n == stop_at) return;
            dev_clk_low = 1'b0;
            bits[n-1] = pin_dat;
            repeat (HALF) @(negedge CLOCK_50);
        end
        dev_rx   = bits[7:0];
        dev_par  = bits[8];
        dev_stop = bits[9];
        if (do_ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
    endtask

    task automatic checkFrame(input string name, input logic [7:0] b, input bit do_ack, input int d0, input int e0);
        checkOutput({name, "_dev_ok"}, 32'(dev_ok), 32'd1);
        checkOutput({name, "_inhibit"}, dev_inh, INHIBIT);
        checkOutput({name, "_start"}, 32'(dev_start), 32'd0);
        checkOutput({name, "_byte"}, 32'(dev_rx), 32'(b));
        checkOutput({name, "_parity"}, 32'(dev_par), 32'(modelParity(b)));
        checkOutput({name, "_stop"}, 32'(dev_stop), 32'd1);
        checkOutput({name, "_done"}, done_cnt - d0, do_ack ? 1 : 0);
        checkOutput({name, "_error"}, error_cnt - e0, do_ack ? 0 : 1);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic runFrame(input string name, input logic [7:0] b, input bit do_ack);
        int d0, e0;
        d0 = done_cnt;
        e0 = error_cnt;
        fork
            deviceFrame(do_ack, 0);
            applyStimulus(b);
        join
        repeat (10) @(negedge CLOCK_50);
        checkFrame(name, b, do_ack, d0, e0);
    endtask

    initial begin
        int d0, e0, w, k;
        logic [7:0] rx1, b;
        logic par1;
        bit ack;

        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        Resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        runFrame("t1", 8'hED, 1'b1);
        runFrame("t2", 8'h01, 1'b0);

        fork
            deviceFrame(1'b1, 4);
            applyStimulus(8'hFF);
        join
        checkOutput("t3_dev_ok", 32'(dev_ok), 32'd1);
        d0 = done_cnt;
        e0 = error_cnt;
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("t3_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("t3_dat_oe", 32'(ps2_dat_oe), 32'd0);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        Resetn = 1'b1;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        checkOutput("t3_no_done", done_cnt - d0, 0);
        checkOutput("t3_no_error", error_cnt - e0, 0);
        runFrame("t3b", 8'h00, 1'b1);

        b = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        e0 = error_cnt;
        fork
            deviceFrame(1'b1, 0);
            begin
                applyStimulus(b);
                repeat (10) @(negedge CLOCK_50);
                send = 1'b1;
                send_data = 8'h55;
                @(negedge CLOCK_50);
                send = 1'b0;
                repeat (150) @(negedge CLOCK_50);
                send = 1'b1;
                send_data = 8'h55;
                @(negedge CLOCK_50);
                send = 1'b0;
            end
        join
        repeat (10) @(negedge CLOCK_50);
        checkFrame("t4", b, 1'b1, d0, e0);

        d0 = done_cnt;
        e0 = error_cnt;
        rx1 = 8'h00;
        par1 = 1'b0;
        fork
            begin
                deviceFrame(1'b1, 0);
                rx1 = dev_rx;
                par1 = dev_par;
                deviceFrame(1'b1, 0);
            end
            begin
                applyStimulus(8'hED);
                w = 0;
                while (done !== 1'b1 && w < 3000) begin
                    @(negedge CLOCK_50);
                    w++;
                end
                checkOutput("t6_done_seen", 32'(w < 3000), 32'd1);
                @(negedge CLOCK_50);
                send = 1'b1;
                send_data = 8'h02;
                @(negedge CLOCK_50);
                send = 1'b0;
            end
        join
        repeat (10) @(negedge CLOCK_50);
        checkOutput("t6_first_byte", 32'(rx1), 32'hED);
        checkOutput("t6_first_par", 32'(par1), 32'(modelParity(8'hED)));
        checkFrame("t6b", 8'h02, 1'b1, d0 + 1, e0);

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            runFrame($sformatf("rnd%0d", i), b, ack);
        end

        e0 = error_cnt;
        applyStimulus(8'h3C);
`ifdef PS2_TX_TIMEOUT_EN
        w = 0;
        while (ps2_clk_oe !== 1'b1 && w < 100) begin
            @(negedge CLOCK_50);
            w++;
        end
        while (ps2_clk_oe === 1'b1 && w < 3000) begin
            @(negedge CLOCK_50);
            w++;
        end
        k = 0;
        while (error !== 1'b1 && k < TIMEOUT + 100) begin
            @(negedge CLOCK_50);
            k++;
        end
        checkOutput("t5_latency", k, TIMEOUT);
        checkOutput("t5_clk_rel", 32'(ps2_clk_oe), 32'd0);
        checkOutput("t5_dat_rel", 32'(ps2_dat_oe), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge CLOCK_50);
        checkOutput("t5_errors", error_cnt - e0, 1);
`else
        k = 0;
        repeat (TIMEOUT + 500) @(negedge CLOCK_50);
        checkOutput("t5_busy_held", 32'(busy), 32'd1);
        checkOutput("t5_no_error", error_cnt - e0, 0);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        checkOutput("t5_busy_reset", 32'(busy), 32'd0);
`endif

        checkOutput("busy_at_done", busy_at_done, 0);
        checkOutput("done_and_error", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
